// File: rtl/reg_file_mp.sv
// reg_file_mp: 1W/2R register file with registered reads and a DEPTH-cycle clear sweep.
// Define REG_BYPASS_EN for write-first reads on a same-edge address match; default is read-first.
module reg_file_mp #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] DIR_A,
  input  logic [ADDR_W-1:0] DIR_B,
  input  logic [ADDR_W-1:0] DIR_WR,
  input  logic [DATA_W-1:0] DI,
  input  logic              WE,
  input  logic              RE,
  input  logic              CLR,
  output logic [DATA_W-1:0] DOA,
  output logic [DATA_W-1:0] DOB,
  output logic              BUSY
);
  localparam int DEPTH = 2 ** ADDR_W;
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] doa_q, doa_d, dob_q, dob_d;
  logic busy_q, busy_d;
  logic wr;
  assign wr = (state_q == IDLE) && !CLR && WE;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    mem_d = mem_q;
    busy_d = busy_q;
    if (state_q == IDLE && CLR) begin
      state_d = CLEAR;
      cnt_d = '0;
      busy_d = 1'b1;
    end else if (state_q == CLEAR) begin
      mem_d[cnt_q] = '0;
      cnt_d = cnt_q + 1'b1;
      state_d = &cnt_q ? IDLE : CLEAR;
      busy_d = !(&cnt_q);
    end else if (wr) begin
      mem_d[DIR_WR] = DI;
    end
`ifdef REG_BYPASS_EN
    doa_d = RE ? ((wr && DIR_A == DIR_WR) ? DI : mem_q[DIR_A]) : doa_q;
    dob_d = RE ? ((wr && DIR_B == DIR_WR) ? DI : mem_q[DIR_B]) : dob_q;
`else
    doa_d = RE ? mem_q[DIR_A] : doa_q;
    dob_d = RE ? mem_q[DIR_B] : dob_q;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      mem_q <= '{default: '0};
      doa_q <= '0;
      dob_q <= '0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      mem_q <= mem_d;
      doa_q <= doa_d;
      dob_q <= dob_d;
      busy_q <= busy_d;
    end
  end
  assign DOA = doa_q;
  assign DOB = dob_q;
  assign BUSY = busy_q;
endmodule
